// File: rtl/md_unit_param.sv
// Parametrised multi-cycle multiply/divide unit holding the HI/LO registers.
// Define MD_UNIT_PARAM_ACC_EN to add madd/maddu/msub/msubu (md_op 9..12).
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             op_err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_PARAM_ACC_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   pend;
    logic                 pend_wr;
    logic                 pend_acc;
    logic                 pend_sub;

    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   prod_u;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH-1:0]     dvs_s;
    logic [WIDTH-1:0]     dvs_u;
    logic [WIDTH-1:0]     uq_s;
    logic [WIDTH-1:0]     ur_s;
    logic [WIDTH-1:0]     q_s;
    logic [WIDTH-1:0]     r_s;
    logic [WIDTH-1:0]     q_u;
    logic [WIDTH-1:0]     r_u;

    logic                 run_op;
    logic                 mthi_op;
    logic                 mtlo_op;
    logic [2*WIDTH-1:0]   nxt_pend;
    logic                 nxt_wr;
    logic                 nxt_acc;
    logic                 nxt_sub;
    logic [CW-1:0]        nxt_cnt;

    // Sign-extending to 2*WIDTH makes the modular product the signed product.
    always_comb begin
        prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} *
                 {{WIDTH{src_b[WIDTH-1]}}, src_b};
        prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    end

    // Magnitude divide, then restore signs; MIN/-1 falls out as lo=MIN, hi=0.
    always_comb begin
        a_neg = src_a[WIDTH-1];
        b_neg = src_b[WIDTH-1];
        abs_a = a_neg ? -src_a : src_a;
        abs_b = b_neg ? -src_b : src_b;
        dvs_s = (abs_b == '0) ? WIDTH'(1) : abs_b;
        dvs_u = (src_b == '0) ? WIDTH'(1) : src_b;
        uq_s  = abs_a / dvs_s;
        ur_s  = abs_a % dvs_s;
        q_s   = (a_neg ^ b_neg) ? -uq_s : uq_s;
        r_s   = a_neg ? -ur_s : ur_s;
        q_u   = src_a / dvs_u;
        r_u   = src_a % dvs_u;
    end

    always_comb begin
        run_op   = 1'b0;
        mthi_op  = 1'b0;
        mtlo_op  = 1'b0;
        nxt_pend = '0;
        nxt_wr   = 1'b1;
        nxt_acc  = 1'b0;
        nxt_sub  = 1'b0;
        nxt_cnt  = MUL_N;
        case (md_op)
            OP_MULT: begin
                run_op   = 1'b1;
                nxt_pend = prod_s;
            end
            OP_MULTU: begin
                run_op   = 1'b1;
                nxt_pend = prod_u;
            end
            OP_DIV: begin
                run_op   = 1'b1;
                nxt_pend = {r_s, q_s};
                nxt_wr   = (src_b != '0);
                nxt_cnt  = DIV_N;
            end
            OP_DIVU: begin
                run_op   = 1'b1;
                nxt_pend = {r_u, q_u};
                nxt_wr   = (src_b != '0);
                nxt_cnt  = DIV_N;
            end
            OP_MTHI: mthi_op = 1'b1;
            OP_MTLO: mtlo_op = 1'b1;
`ifdef MD_UNIT_PARAM_ACC_EN
            OP_MADD: begin
                run_op   = 1'b1;
                nxt_pend = prod_s;
                nxt_acc  = 1'b1;
            end
            OP_MADDU: begin
                run_op   = 1'b1;
                nxt_pend = prod_u;
                nxt_acc  = 1'b1;
            end
            OP_MSUB: begin
                run_op   = 1'b1;
                nxt_pend = prod_s;
                nxt_acc  = 1'b1;
                nxt_sub  = 1'b1;
            end
            OP_MSUBU: begin
                run_op   = 1'b1;
                nxt_pend = prod_u;
                nxt_acc  = 1'b1;
                nxt_sub  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= '0;
            pend_wr  <= 1'b0;
            pend_acc <= 1'b0;
            pend_sub <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            done   <= 1'b0;
            op_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (run_op) begin
                            pend     <= nxt_pend;
                            pend_wr  <= nxt_wr;
                            pend_acc <= nxt_acc;
                            pend_sub <= nxt_sub;
                            cnt      <= nxt_cnt;
                            state    <= RUN;
                        end else if (mthi_op) begin
                            hi <= src_a;
                        end else if (mtlo_op) begin
                            lo <= src_a;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (start) op_err <= 1'b1;
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        // Accumulate reads HI/LO as they stand at commit.
                        if (pend_wr) begin
                            if (!pend_acc)
                                {hi, lo} <= pend;
                            else if (pend_sub)
                                {hi, lo} <= {hi, lo} - pend;
                            else
                                {hi, lo} <= {hi, lo} + pend;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
